// File: rtl/julia_engine.sv
// Julia-set frame generator: iterates z = z^2 + c per LCD pixel and writes packed 8-bit escape counts to SDRAM.
// Optional JULIA_ENGINE_ANIMATE_EN: free-running frames with c_re advanced by C_STEP after each frame.
module julia_engine #(
  parameter int          H_RES     = 800,
  parameter int          V_RES     = 480,
  parameter int          MAX_ITER  = 255,
  parameter logic [21:0] BASE_ADDR = 22'd0,
  parameter logic [15:0] X_START   = 16'hE000,
  parameter logic [15:0] Y_START   = 16'h1333,
  parameter logic [15:0] STEP      = 16'h0014,
  parameter logic [1:0]  CMD_NOP   = 2'd0,
  parameter logic [1:0]  CMD_WRITE = 2'd2,
  parameter logic [15:0] C_STEP    = 16'h0008
) (
  input  logic        i_Clk,
  input  logic        i_Rst_N,
  input  logic        i_Begin,
  input  logic [15:0] i_C_Re,
  input  logic [15:0] i_C_Im,
  input  logic        i_Data_Write_Done,
  output logic [1:0]  o_Command,
  output logic [21:0] o_Data_Address,
  output logic [31:0] o_Data_Write,
  output logic        o_Busy,
  output logic        o_Frame_Done
);

  localparam int X_W = $clog2(H_RES + 1);
  localparam int Y_W = $clog2(V_RES + 1);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_ITER, S_WRITE} state_t;

  state_t                r_State;
  logic signed [15:0]    r_Cr, r_Ci;
  logic signed [15:0]    r_Z0r, r_Z0i;
  logic signed [15:0]    r_Zr, r_Zi;
  logic [7:0]            r_N;
  logic [X_W-1:0]        r_X;
  logic [Y_W-1:0]        r_Y;
  logic [23:0]           r_Pack;

  // Q8.24 product back to Q4.12, keeping the low 16 bits
  function automatic logic signed [15:0] fx_trunc(input logic signed [31:0] prod,
                                                  input int unsigned sh);
    logic signed [31:0] s;
    s = prod >>> sh;
    return s[15:0];
  endfunction

  logic signed [31:0] w_ZrSq, w_ZiSq, w_ZrZi;
  logic [32:0]        w_Mag;
  logic               w_Esc, w_PixDone;
  logic [7:0]         w_Pixel;
  logic signed [15:0] w_ZrNext, w_ZiNext;

  assign w_ZrSq    = r_Zr * r_Zr;
  assign w_ZiSq    = r_Zi * r_Zi;
  assign w_ZrZi    = r_Zr * r_Zi;
  assign w_Mag     = {1'b0, w_ZrSq} + {1'b0, w_ZiSq};
  assign w_Esc     = w_Mag > 33'h0_0400_0000;
  assign w_PixDone = w_Esc || (({1'b0, r_N} + 9'd1) == 9'(MAX_ITER));
  assign w_Pixel   = w_Esc ? r_N : 8'(MAX_ITER);
  assign w_ZrNext  = fx_trunc(w_ZrSq - w_ZiSq, 12) + r_Cr;
  assign w_ZiNext  = fx_trunc(w_ZrZi, 11) + r_Ci;

  logic               w_LastX, w_LastY;
  logic [X_W-1:0]     w_XNext;
  logic [Y_W-1:0]     w_YNext;
  logic signed [15:0] w_Z0rNext, w_Z0iNext;

  assign w_LastX   = (r_X == X_W'(H_RES - 1));
  assign w_LastY   = (r_Y == Y_W'(V_RES - 1));
  assign w_XNext   = w_LastX ? '0 : r_X + X_W'(1);
  assign w_YNext   = w_LastX ? r_Y + Y_W'(1) : r_Y;
  assign w_Z0rNext = w_LastX ? $signed(X_START) : r_Z0r + $signed(STEP);
  assign w_Z0iNext = w_LastX ? r_Z0i - $signed(STEP) : r_Z0i;

  // z datapath: loaded in INIT, iterated in ITER; no reset needed
  always_ff @(posedge i_Clk) begin
    if (r_State == S_INIT) begin
      r_Zr <= r_Z0r;
      r_Zi <= r_Z0i;
    end else if (r_State == S_ITER) begin
      r_Zr <= w_ZrNext;
      r_Zi <= w_ZiNext;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_N) begin
      r_State        <= S_IDLE;
      r_Cr           <= '0;
      r_Ci           <= '0;
      r_Z0r          <= '0;
      r_Z0i          <= '0;
      r_N            <= '0;
      r_X            <= '0;
      r_Y            <= '0;
      r_Pack         <= '0;
      o_Command      <= CMD_NOP;
      o_Data_Address <= '0;
      o_Data_Write   <= '0;
      o_Busy         <= 1'b0;
      o_Frame_Done   <= 1'b0;
    end else begin
      o_Frame_Done <= 1'b0;
      case (r_State)
        S_IDLE: begin
          if (i_Begin) begin
            r_Cr           <= $signed(i_C_Re);
            r_Ci           <= $signed(i_C_Im);
            r_X            <= '0;
            r_Y            <= '0;
            r_Z0r          <= $signed(X_START);
            r_Z0i          <= $signed(Y_START);
            o_Data_Address <= BASE_ADDR;
            o_Busy         <= 1'b1;
            r_State        <= S_INIT;
          end
        end
        S_INIT: begin
          r_N     <= '0;
          r_State <= S_ITER;
        end
        S_ITER: begin
          if (w_PixDone) begin
            case (r_X[1:0])
              2'd0:    r_Pack[7:0]   <= w_Pixel;
              2'd1:    r_Pack[15:8]  <= w_Pixel;
              2'd2:    r_Pack[23:16] <= w_Pixel;
              default: r_Pack        <= r_Pack;
            endcase
            if (r_X[1:0] == 2'd3) begin
              o_Data_Write <= {w_Pixel, r_Pack};
              o_Command    <= CMD_WRITE;
              r_State      <= S_WRITE;
            end else begin
              r_X     <= w_XNext;
              r_Y     <= w_YNext;
              r_Z0r   <= w_Z0rNext;
              r_Z0i   <= w_Z0iNext;
              r_State <= S_INIT;
            end
          end else begin
            r_N <= r_N + 8'd1;
          end
        end
        S_WRITE: begin
          if (i_Data_Write_Done) begin
            o_Command <= CMD_NOP;
            if (w_LastX && w_LastY) begin
              o_Frame_Done <= 1'b1;
              // c is relatched on the next i_Begin, so this only matters when animating
              r_Cr         <= r_Cr + $signed(C_STEP);
`ifdef JULIA_ENGINE_ANIMATE_EN
              r_X            <= '0;
              r_Y            <= '0;
              r_Z0r          <= $signed(X_START);
              r_Z0i          <= $signed(Y_START);
              o_Data_Address <= BASE_ADDR;
              r_State        <= S_INIT;
`else
              o_Busy  <= 1'b0;
              r_State <= S_IDLE;
`endif
            end else begin
              r_X            <= w_XNext;
              r_Y            <= w_YNext;
              r_Z0r          <= w_Z0rNext;
              r_Z0i          <= w_Z0iNext;
              o_Data_Address <= o_Data_Address + 22'd1;
              r_State        <= S_INIT;
            end
          end
        end
        default: r_State <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_julia_engine.sv
// Directed bench for julia_engine: two small-frame instances (escape-count frame and all-capped frame).
module tb_julia_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, begin_p, done_p, sel;
  logic [15:0] c_re, c_im;

  logic        begin_a, begin_b, done_a, done_b;
  logic [1:0]  cmd_a, cmd_b;
  logic [21:0] addr_a, addr_b;
  logic [31:0] data_a, data_b;
  logic        busy_a, busy_b, fd_a, fd_b;

  assign begin_a = begin_p & ~sel;
  assign begin_b = begin_p & sel;
  assign done_a  = done_p & ~sel;
  assign done_b  = done_p & sel;

  logic [1:0]  w_cmd;
  logic [21:0] w_addr;
  logic [31:0] w_data;
  logic        w_busy, w_fd;
  assign w_cmd  = sel ? cmd_b  : cmd_a;
  assign w_addr = sel ? addr_b : addr_a;
  assign w_data = sel ? data_b : data_a;
  assign w_busy = sel ? busy_b : busy_a;
  assign w_fd   = sel ? fd_b   : fd_a;

  julia_engine #(
    .H_RES(4), .V_RES(1), .MAX_ITER(255), .BASE_ADDR(22'h2A),
    .X_START(16'h2000), .Y_START(16'h0000), .STEP(16'h1000)
  ) u_esc (
    .i_Clk(clk), .i_Rst_N(rst_n), .i_Begin(begin_a), .i_C_Re(c_re), .i_C_Im(c_im),
    .i_Data_Write_Done(done_a), .o_Command(cmd_a), .o_Data_Address(addr_a),
    .o_Data_Write(data_a), .o_Busy(busy_a), .o_Frame_Done(fd_a)
  );

  julia_engine #(
    .H_RES(4), .V_RES(2), .MAX_ITER(255), .BASE_ADDR(22'h100),
    .X_START(16'h0000), .Y_START(16'h0000), .STEP(16'h0000)
  ) u_cap (
    .i_Clk(clk), .i_Rst_N(rst_n), .i_Begin(begin_b), .i_C_Re(c_re), .i_C_Im(c_im),
    .i_Data_Write_Done(done_b), .o_Command(cmd_b), .o_Data_Address(addr_b),
    .o_Data_Write(data_b), .o_Busy(busy_b), .o_Frame_Done(fd_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [15:0] cr, input logic [15:0] ci);
    c_re = cr;
    c_im = ci;
    begin_p = 1'b1;
    tick();
    begin_p = 1'b0;
  endtask

  task automatic pulse_done();
    done_p = 1'b1;
    tick();
    done_p = 1'b0;
  endtask

  task automatic wait_write(input int budget, output int cnt);
    cnt = 0;
    while (w_cmd !== 2'd2 && cnt < budget) begin
      tick();
      cnt++;
    end
    chk("write_seen", {30'd0, w_cmd}, 32'd2);
  endtask

  int cnt;

  initial begin
    rst_n = 1'b0; begin_p = 1'b0; done_p = 1'b0; sel = 1'b0;
    c_re = '0; c_im = '0;
    repeat (3) tick();

    // reset state of both instances
    chk("rst_cmd_a",  {30'd0, cmd_a}, 32'd0);
    chk("rst_addr_a", {10'd0, addr_a}, 32'd0);
    chk("rst_data_a", data_a, 32'd0);
    chk("rst_busy_a", {31'd0, busy_a}, 32'd0);
    chk("rst_fd_a",   {31'd0, fd_a}, 32'd0);
    chk("rst_busy_b", {31'd0, busy_b}, 32'd0);
    chk("rst_cmd_b",  {30'd0, cmd_b}, 32'd0);
    rst_n = 1'b1;
    tick();

    // escape counts: 2.0 escapes at n=1, 3.0/4.0/5.0 at n=0
    sel = 1'b0; #1;
    start(16'h0000, 16'h0000);
    chk("esc_busy", {31'd0, w_busy}, 32'd1);
    wait_write(50, cnt);
    chk("esc_latency", cnt, 32'd9);
    chk("esc_addr", {10'd0, w_addr}, 32'h2A);
    chk("esc_data", w_data, 32'h0000_0001);
    pulse_done();
    chk("esc_cmd_nop", {30'd0, w_cmd}, 32'd0);
    chk("esc_fd", {31'd0, w_fd}, 32'd1);
    chk("esc_busy_end", {31'd0, w_busy}, 32'd0);
    tick();
    chk("esc_fd_clear", {31'd0, w_fd}, 32'd0);

    // capped frame with delayed write done
    sel = 1'b1; #1;
    start(16'h0000, 16'h0000);
    wait_write(1200, cnt);
    chk("cap_latency", cnt, 32'd1024);
    chk("cap_addr0", {10'd0, w_addr}, 32'h100);
    chk("cap_data0", w_data, 32'hFFFF_FFFF);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_cmd",  {30'd0, w_cmd}, 32'd2);
      chk("hold_addr", {10'd0, w_addr}, 32'h100);
      chk("hold_data", w_data, 32'hFFFF_FFFF);
    end
    pulse_done();
    chk("cap_cmd_nop", {30'd0, w_cmd}, 32'd0);
    chk("cap_busy_mid", {31'd0, w_busy}, 32'd1);
    chk("cap_fd_mid", {31'd0, w_fd}, 32'd0);
    pulse_done();  // stray done outside WRITE
    wait_write(1200, cnt);
    chk("cap_addr1", {10'd0, w_addr}, 32'h101);
    chk("cap_data1", w_data, 32'hFFFF_FFFF);
    pulse_done();
    chk("cap_fd", {31'd0, w_fd}, 32'd1);
    chk("cap_busy_end", {31'd0, w_busy}, 32'd0);
    tick();
    chk("cap_fd_once", {31'd0, w_fd}, 32'd0);

    // begin while busy with a c that would escape quickly
    start(16'h0000, 16'h0000);
    repeat (5) tick();
    start(16'h1000, 16'h0000);
    c_re = '0;
    wait_write(1200, cnt);
    chk("bwb_addr0", {10'd0, w_addr}, 32'h100);
    chk("bwb_data0", w_data, 32'hFFFF_FFFF);
    pulse_done();
    wait_write(1200, cnt);
    chk("bwb_addr1", {10'd0, w_addr}, 32'h101);
    chk("bwb_data1", w_data, 32'hFFFF_FFFF);
    pulse_done();
    chk("bwb_fd", {31'd0, w_fd}, 32'd1);
    tick();

    // reset during the third pixel's iterations
    start(16'h0000, 16'h0000);
    repeat (600) tick();
    chk("mid_busy", {31'd0, w_busy}, 32'd1);
    chk("mid_cmd", {30'd0, w_cmd}, 32'd0);
    rst_n = 1'b0;
    tick();
    chk("mrst_cmd",  {30'd0, w_cmd}, 32'd0);
    chk("mrst_addr", {10'd0, w_addr}, 32'd0);
    chk("mrst_data", w_data, 32'd0);
    chk("mrst_busy", {31'd0, w_busy}, 32'd0);
    chk("mrst_fd",   {31'd0, w_fd}, 32'd0);
    rst_n = 1'b1;
    tick();
    start(16'h0000, 16'h0000);
    wait_write(1200, cnt);
    chk("rs_latency", cnt, 32'd1024);
    chk("rs_addr0", {10'd0, w_addr}, 32'h100);
    chk("rs_data0", w_data, 32'hFFFF_FFFF);
    pulse_done();
    wait_write(1200, cnt);
    chk("rs_addr1", {10'd0, w_addr}, 32'h101);
    pulse_done();
    chk("rs_fd", {31'd0, w_fd}, 32'd1);
    tick();

`ifdef JULIA_ENGINE_ANIMATE_EN
    // free-running frames: second frame restarts at pixel (0,0)
    sel = 1'b0; #1;
    start(16'h0000, 16'h0000);
    wait_write(50, cnt);
    chk("ani_addr0", {10'd0, w_addr}, 32'h2A);
    chk("ani_data0", w_data, 32'h0000_0001);
    pulse_done();
    chk("ani_fd0", {31'd0, w_fd}, 32'd1);
    chk("ani_busy0", {31'd0, w_busy}, 32'd1);
    tick();
    chk("ani_fd_clear", {31'd0, w_fd}, 32'd0);
    wait_write(50, cnt);
    chk("ani_addr1", {10'd0, w_addr}, 32'h2A);
    chk("ani_data1", w_data, 32'h0000_0001);
    pulse_done();
    chk("ani_fd1", {31'd0, w_fd}, 32'd1);
    chk("ani_busy1", {31'd0, w_busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("ani_rst_busy", {31'd0, w_busy}, 32'd0);
    rst_n = 1'b1;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/julia_engine.md
Name: julia_engine

Overview:
- Fractal compute stage that fills the SDRAM frame buffer. It feeds the processor input (select value 2) of the SDRAM command mux.
- For each LCD pixel it iterates z = z^2 + c in signed fixed point and records the escape iteration count as an 8-bit pixel.
- It packs four pixels per 32-bit word and writes each word through the SDRAM controller command/done handshake.
- The frame reader later streams these words to the pixel FIFO.

Parameters:
- H_RES, 800, pixels per line; must be a multiple of 4.
- V_RES, 480, lines per frame.
- MAX_ITER, 255, iteration cap (1..255).
- BASE_ADDR, 22'd0, word address of pixel (0,0).
- X_START, 16'hE000, real part of z0 at x=0, Q4.12 (-2.0).
- Y_START, 16'h1333, imaginary part of z0 at y=0, Q4.12 (~1.2).
- STEP, 16'h0014, pixel pitch, Q4.12.
- CMD_NOP, 2'd0, controller idle command code.
- CMD_WRITE, 2'd2, controller write command code.
- C_STEP, 16'h0008, per-frame c_re increment, Q4.12 (optional feature only).

Ports:
- i_Clk  in  1  memory clock (MEM_CLK domain).
- i_Rst_N  in  1  synchronous active-low reset.
- i_Begin  in  1  start pulse; ignored unless idle.
- i_C_Re  in  16  c real part, Q4.12, sampled on accepted i_Begin.
- i_C_Im  in  16  c imaginary part, Q4.12, sampled on accepted i_Begin.
- i_Data_Write_Done  in  1  one-cycle pulse from controller when the write completes.
- o_Command  out  2  CMD_NOP or CMD_WRITE to the mux.
- o_Data_Address  out  22  word address.
- o_Data_Write  out  32  packed pixel word.
- o_Busy  out  1  high from accepted i_Begin until frame completes.
- o_Frame_Done  out  1  one-cycle pulse after the last word's write done.

Behaviour:
- Reset (i_Rst_N=0 at a clock edge), effective regardless of state, including mid-iteration or mid-write:
  - State goes to IDLE.
  - o_Command=CMD_NOP, o_Data_Address=0, o_Data_Write=0, o_Busy=0, o_Frame_Done=0.
  - Pixel counters, word packer and c registers are cleared.
- Arithmetic:
  - All z and c values are signed Q4.12. Products are 32-bit Q8.24.
  - zr' = ((zr*zr - zi*zi) >>> 12) + cr.
  - zi' = ((zr*zi) >>> 11) + ci.
  - Right shifts are arithmetic; results are truncated to 16 bits.
  - Escape test: the 33-bit unsigned sum zr*zr + zi*zi > 33'h0_0400_0000 (strictly greater than 4.0).
  - c is constrained by the user to |re|,|im| < 2.0. No overflow handling beyond truncation.
- IDLE:
  - On i_Begin, latch c, set x=y=0, z0_re=X_START, z0_im=Y_START, o_Busy=1 -> INIT.
- INIT (1 cycle):
  - z <= z0, n <= 0 -> ITER.
- ITER (one iteration test per cycle):
  - If escape: pixel = n.
  - Else if n+1 == MAX_ITER: pixel = MAX_ITER.
  - Else z <= z', n <= n+1, stay in ITER.
  - When a pixel is produced, it goes into byte lane x[1:0] of the packer, where lane k occupies bits [8k+7:8k].
  - If x[1:0]==3 -> WRITE. Otherwise advance to the next pixel -> INIT.
- Pixel advance:
  - x+1 and z0_re += STEP.
  - At x == H_RES-1: x=0, z0_re=X_START, y+1, z0_im -= STEP.
- WRITE:
  - o_Command=CMD_WRITE, o_Data_Write=packed word.
  - o_Data_Address = BASE_ADDR + (y*H_RES + x)/4, maintained as an incrementing counter.
  - All three outputs are held stable until i_Data_Write_Done.
- On i_Data_Write_Done:
  - o_Command <= CMD_NOP in the following cycle.
  - If the last word of the frame: o_Frame_Done pulses 1 cycle, o_Busy <= 0 -> IDLE.
  - Otherwise advance pixel -> INIT.
- Handshake and edge cases:
  - A done pulse outside WRITE is ignored.
  - i_Begin while busy is ignored.
  - The frame is exactly H_RES*V_RES/4 writes, at addresses BASE_ADDR .. BASE_ADDR + H_RES*V_RES/4 - 1.
  - Latency per pixel = 1 + number of ITER cycles. Pixel value n takes n+1 ITER cycles; a capped pixel takes MAX_ITER cycles.

Optional Feature:
- Macro JULIA_ENGINE_ANIMATE_EN.
- When defined, on the last write done:
  - c_re <= c_re + C_STEP and the engine re-enters INIT at pixel (0,0) with o_Busy held 1.
  - o_Frame_Done still pulses once per frame.
  - i_Begin while busy still has no effect; only reset stops the engine.
- When undefined: single frame per i_Begin, and C_STEP is unused.

Test Plan:
- Escape counts: H_RES=4, V_RES=1, X_START=16'h2000, STEP=16'h1000, Y_START=0, c=0. Start -> one write, address BASE_ADDR, data 32'h0000_0001 (z0=2.0 escapes at n=1; 3.0, 4.0, 5.0 at n=0), then o_Frame_Done pulse and o_Busy=0.
- Capped pixels: H_RES=4, V_RES=2, X_START=Y_START=STEP=0, c=0. Start -> writes 32'hFFFF_FFFF to BASE_ADDR then BASE_ADDR+1. o_Frame_Done pulses exactly once, one cycle after the second done.
- Write hold: delay i_Data_Write_Done 10 cycles. o_Command, o_Data_Address and o_Data_Write stay constant throughout, and o_Command returns to CMD_NOP the cycle after done.
- Reset mid-frame: assert i_Rst_N=0 during ITER of the 3rd pixel -> next cycle all outputs at reset values. A new i_Begin restarts at BASE_ADDR.
- Begin while busy: pulse i_Begin with a different c during the frame -> ignored; output words match the uninterrupted run.
- Animate (JULIA_ENGINE_ANIMATE_EN): 4x1 frame, c_re=0 -> second frame starts automatically with c_re=16'h0008. o_Frame_Done pulses per frame and o_Busy stays high.
